// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the decoder result record used by the ID/EX stage.
// The ALU op codes here must stay bit-identical to the execute ALU's select encoding.
package mips_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOP = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [2:0] alucon;
      logic       use_imm;
      logic       sext;
      logic       dst_rd;
      logic       wr;
      logic       mem_rd;
      logic       mem_wr;
      logic       rt_src;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Purely combinational opcode/funct decoder: ALU select, operand-B source,
// extension mode, destination select, write/memory controls and illegal flag.
import mips_pkg::*;

module alu_decode (
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec        = '0;
      dec.alucon = ALU_NOP;
      case (opcode)
         OP_RTYPE: begin
            dec.rt_src = 1'b1;
            dec.dst_rd = 1'b1;
            dec.wr     = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec.alucon = ALU_ADD;
               FN_SUB, FN_SUBU: dec.alucon = ALU_SUB;
               FN_AND:          dec.alucon = ALU_AND;
               FN_OR:           dec.alucon = ALU_OR;
               default: begin
                  dec.wr      = 1'b0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec.alucon  = ALU_ADD;
            dec.use_imm = 1'b1;
            dec.sext    = 1'b1;
            dec.wr      = 1'b1;
         end
         OP_ANDI: begin
            dec.alucon  = ALU_AND;
            dec.use_imm = 1'b1;
            dec.wr      = 1'b1;
         end
         OP_ORI: begin
            dec.alucon  = ALU_OR;
            dec.use_imm = 1'b1;
            dec.wr      = 1'b1;
         end
         OP_LW: begin
            dec.alucon  = ALU_ADD;
            dec.use_imm = 1'b1;
            dec.sext    = 1'b1;
            dec.wr      = 1'b1;
            dec.mem_rd  = 1'b1;
         end
         OP_SW: begin
            // rt is read as store data, so it is a hazard source
            dec.alucon  = ALU_ADD;
            dec.use_imm = 1'b1;
            dec.sext    = 1'b1;
            dec.mem_wr  = 1'b1;
            dec.rt_src  = 1'b1;
         end
         OP_BEQ: begin
            dec.alucon = ALU_SUB;
            dec.rt_src = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decode, immediate extension, two-level forwarding,
// load-use bubble insertion, downstream stall and flush, one-cycle latency.
import mips_pkg::*;

module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [5:0]    in_opcode,
   input  logic [5:0]    in_funct,
   input  logic [RW-1:0] in_rs,
   input  logic [RW-1:0] in_rt,
   input  logic [RW-1:0] in_rd,
   input  logic [15:0]   in_imm,
   input  logic [DW-1:0] in_rs_data,
   input  logic [DW-1:0] in_rt_data,
   input  logic          fwd1_wr,
   input  logic [RW-1:0] fwd1_rd,
   input  logic [DW-1:0] fwd1_data,
   input  logic          fwd2_wr,
   input  logic [RW-1:0] fwd2_rd,
   input  logic [DW-1:0] fwd2_data,
   input  logic          stall,
   input  logic          flush,
   output logic          ex_valid,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [2:0]    ex_alucon,
   output logic [RW-1:0] ex_dst,
   output logic          ex_wr,
   output logic          ex_mem_rd,
   output logic          ex_mem_wr,
   output logic [DW-1:0] ex_store_data,
   output logic          ex_illegal
);

   dec_t          dec;
   logic [DW-1:0] rs_val_p0, rt_val_p0, imm_p0, b_p0;
   logic [RW-1:0] dst_p0;
   logic          wr_p0, luh, take_p0, illegal_p0;

   // Register 0 is hard-wired zero; the EX-stage result beats the MEM-stage one
   function automatic logic [DW-1:0] forward(
      input logic [RW-1:0] idx,  input logic [DW-1:0] rf,
      input logic          w1,   input logic [RW-1:0] r1, input logic [DW-1:0] d1,
      input logic          w2,   input logic [RW-1:0] r2, input logic [DW-1:0] d2);
      if (idx == '0)             return '0;
      else if (w1 && r1 == idx)  return d1;
      else if (w2 && r2 == idx)  return d2;
      else                       return rf;
   endfunction

   alu_decode u_dec (
      .opcode (in_opcode),
      .funct  (in_funct),
      .dec    (dec)
   );

   always_comb begin
      rs_val_p0  = forward(in_rs, in_rs_data, fwd1_wr, fwd1_rd, fwd1_data, fwd2_wr, fwd2_rd, fwd2_data);
      rt_val_p0  = forward(in_rt, in_rt_data, fwd1_wr, fwd1_rd, fwd1_data, fwd2_wr, fwd2_rd, fwd2_data);
      imm_p0     = dec.sext ? {{(DW-16){in_imm[15]}}, in_imm} : {{(DW-16){1'b0}}, in_imm};
      b_p0       = dec.use_imm ? imm_p0 : rt_val_p0;
      dst_p0     = dec.dst_rd ? in_rd : in_rt;
      wr_p0      = dec.wr && (dst_p0 != '0);
      luh        = ex_valid && ex_mem_rd && (ex_dst != '0) && in_valid &&
                   ((ex_dst == in_rs) || (dec.rt_src && (ex_dst == in_rt)));
      take_p0    = !flush && !luh && in_valid && !dec.illegal;
      illegal_p0 = !flush && !luh && in_valid && dec.illegal;
   end

   assign in_ready = !stall && !luh;

   // ID -> EX register boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_a          <= '0;
         ex_b          <= '0;
         ex_alucon     <= ALU_NOP;
         ex_dst        <= '0;
         ex_wr         <= 1'b0;
         ex_mem_rd     <= 1'b0;
         ex_mem_wr     <= 1'b0;
         ex_store_data <= '0;
         ex_illegal    <= 1'b0;
      end else if (stall && !flush) begin
         ex_illegal <= 1'b0;
      end else begin
         ex_valid      <= take_p0;
         ex_a          <= take_p0 ? rs_val_p0 : '0;
         ex_b          <= take_p0 ? b_p0 : '0;
         ex_alucon     <= take_p0 ? dec.alucon : ALU_NOP;
         ex_dst        <= take_p0 ? dst_p0 : '0;
         ex_wr         <= take_p0 && wr_p0;
         ex_mem_rd     <= take_p0 && dec.mem_rd;
         ex_mem_wr     <= take_p0 && dec.mem_wr;
         ex_store_data <= take_p0 ? rt_val_p0 : DW'(NOP_WORD);
         ex_illegal    <= illegal_p0;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready;
   logic [5:0]  in_opcode, in_funct;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [31:0] in_rs_data, in_rt_data;
   logic        fwd1_wr, fwd2_wr;
   logic [4:0]  fwd1_rd, fwd2_rd;
   logic [31:0] fwd1_data, fwd2_data;
   logic        stall, flush;
   logic        ex_valid, ex_wr, ex_mem_rd, ex_mem_wr, ex_illegal;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [2:0]  ex_alucon;
   logic [4:0]  ex_dst;

   int checks = 0;
   int errors = 0;

   // model of the registered stage outputs
   logic        m_valid, m_wr, m_mrd, m_mwr, m_ill;
   logic [31:0] m_a, m_b, m_sd;
   logic [2:0]  m_alu;
   logic [4:0]  m_dst;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_imm(in_imm), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .fwd1_wr(fwd1_wr), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
      .fwd2_wr(fwd2_wr), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
      .ex_alucon(ex_alucon), .ex_dst(ex_dst), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
   );

   function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 0) return 32'h0;
      if (fwd1_wr && fwd1_rd == idx) return fwd1_data;
      if (fwd2_wr && fwd2_rd == idx) return fwd2_data;
      return rf;
   endfunction

   function automatic bit ref_luh();
      bit rt_used;
      rt_used = (in_opcode == 6'h00) || (in_opcode == 6'h2B) || (in_opcode == 6'h04);
      return m_valid && m_mrd && (m_dst != 0) && in_valid &&
             ((m_dst == in_rs) || (rt_used && m_dst == in_rt));
   endfunction

   task automatic model_bubble();
      m_valid = 0; m_wr = 0; m_mrd = 0; m_mwr = 0; m_alu = 3'b111;
      m_a = 0; m_b = 0; m_dst = 0; m_sd = 0; m_ill = 0;
   endtask

   // Advance one clock; the model is evaluated from the inputs seen before the edge
   task automatic tick();
      logic [31:0] a, rb, bv, sx, zx;
      logic [2:0]  alu;
      logic [4:0]  dst;
      bit ok, wrt, ld, st, luh;
      a  = ref_fwd(in_rs, in_rs_data);
      rb = ref_fwd(in_rt, in_rt_data);
      zx = {16'h0, in_imm};
      sx = in_imm[15] ? (32'hFFFF_0000 | zx) : zx;
      ok = 1; wrt = 1; ld = 0; st = 0; dst = in_rt; alu = 3'b111; bv = rb;
      case (in_opcode)
         6'h00: begin
            dst = in_rd;
            case (in_funct)
               6'h20, 6'h21: alu = 3'b000;
               6'h22, 6'h23: alu = 3'b001;
               6'h24:        alu = 3'b010;
               6'h25:        alu = 3'b011;
               default:      ok = 0;
            endcase
         end
         6'h08, 6'h09: begin alu = 3'b000; bv = sx; end
         6'h0C:        begin alu = 3'b010; bv = zx; end
         6'h0D:        begin alu = 3'b011; bv = zx; end
         6'h23:        begin alu = 3'b000; bv = sx; ld = 1; end
         6'h2B:        begin alu = 3'b000; bv = sx; st = 1; wrt = 0; end
         6'h04:        begin alu = 3'b001; wrt = 0; end
         default:      ok = 0;
      endcase
      luh = ref_luh();
      @(posedge clk); #1;
      if (rst) model_bubble();
      else if (flush) model_bubble();
      else if (stall) m_ill = 0;
      else if (luh || !in_valid || !ok) begin
         model_bubble();
         m_ill = in_valid && !ok && !luh;
      end else begin
         m_valid = 1; m_a = a; m_b = bv; m_alu = alu; m_dst = dst;
         m_wr = wrt && (dst != 0); m_mrd = ld; m_mwr = st; m_sd = rb; m_ill = 0;
      end
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; in_opcode = 0; in_funct = 0; in_rs = 0; in_rt = 0; in_rd = 0;
      in_imm = 0; in_rs_data = 0; in_rt_data = 0; fwd1_wr = 0; fwd1_rd = 0; fwd1_data = 0;
      fwd2_wr = 0; fwd2_rd = 0; fwd2_data = 0; stall = 0; flush = 0;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                            input logic [31:0] rsd, input logic [31:0] rtd);
      in_valid = 1; in_opcode = op; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_rs_data = rsd; in_rt_data = rtd;
   endtask

   task automatic test_reset();
      idle();
      set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'h5, 32'h7);
      rst = 1;
      tick(); tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
      checks++; if (ex_alucon !== 3'b111) begin errors++; $display("FAIL reset_alucon got %b want 111", ex_alucon); end
      checks++; if (ex_a !== 32'h0 || ex_b !== 32'h0 || ex_store_data !== 32'h0) begin
         errors++; $display("FAIL reset_data got a=%h b=%h sd=%h want 0", ex_a, ex_b, ex_store_data); end
      checks++; if ({ex_dst, ex_wr, ex_mem_rd, ex_mem_wr, ex_illegal} !== 9'h0) begin
         errors++; $display("FAIL reset_ctrl got dst=%0d wr=%b mr=%b mw=%b il=%b want 0", ex_dst, ex_wr, ex_mem_rd, ex_mem_wr, ex_illegal); end
      idle();
   endtask

   task automatic test_decode();
      idle();
      set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 32'd5, 32'd7);
      tick();
      checks++; if (ex_a !== 32'd5) begin errors++; $display("FAIL add_a got %h want 5", ex_a); end
      checks++; if (ex_b !== 32'd7) begin errors++; $display("FAIL add_b got %h want 7", ex_b); end
      checks++; if (ex_alucon !== 3'b000) begin errors++; $display("FAIL add_alucon got %b want 000", ex_alucon); end
      checks++; if (ex_dst !== 5'd3) begin errors++; $display("FAIL add_dst got %0d want 3", ex_dst); end
      checks++; if (ex_wr !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL add_wr_valid got wr=%b v=%b want 1 1", ex_wr, ex_valid); end
      set_instr(6'h00, 6'h22, 5'd1, 5'd2, 5'd0, 16'h0, 32'd9, 32'd4);
      tick();
      checks++; if (ex_alucon !== 3'b001 || ex_wr !== 1'b0) begin errors++; $display("FAIL sub_r0 got alu=%b wr=%b want 001 0", ex_alucon, ex_wr); end
      idle();
   endtask

   task automatic test_immediates();
      idle();
      set_instr(6'h08, 6'h00, 5'd1, 5'd6, 5'd0, 16'hFFFF, 32'd1, 32'd2);
      tick();
      checks++; if (ex_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_b got %h want ffffffff", ex_b); end
      checks++; if (ex_dst !== 5'd6 || ex_wr !== 1'b1) begin errors++; $display("FAIL addi_dst got %0d wr=%b want 6 1", ex_dst, ex_wr); end
      set_instr(6'h0D, 6'h00, 5'd1, 5'd6, 5'd0, 16'h8001, 32'd1, 32'd2);
      tick();
      checks++; if (ex_b !== 32'h0000_8001) begin errors++; $display("FAIL ori_b got %h want 00008001", ex_b); end
      checks++; if (ex_alucon !== 3'b011) begin errors++; $display("FAIL ori_alucon got %b want 011", ex_alucon); end
      set_instr(6'h2B, 6'h00, 5'd1, 5'd6, 5'd0, 16'hFFF0, 32'd100, 32'hCAFE);
      tick();
      checks++; if (ex_mem_wr !== 1'b1 || ex_wr !== 1'b0 || ex_store_data !== 32'hCAFE || ex_b !== 32'hFFFF_FFF0) begin
         errors++; $display("FAIL sw got mw=%b wr=%b sd=%h b=%h want 1 0 cafe fffffff0", ex_mem_wr, ex_wr, ex_store_data, ex_b); end
      set_instr(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 16'h0, 32'd1, 32'd2);
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_illegal !== 1'b1 || ex_alucon !== 3'b111) begin
         errors++; $display("FAIL illegal got v=%b il=%b alu=%b want 0 1 111", ex_valid, ex_illegal, ex_alucon); end
      idle();
      tick();
      checks++; if (ex_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse got %b want 0", ex_illegal); end
   endtask

   task automatic test_forward();
      idle();
      set_instr(6'h00, 6'h21, 5'd4, 5'd5, 5'd7, 16'h0, 32'h11, 32'h22);
      fwd1_wr = 1; fwd1_rd = 4; fwd1_data = 32'hAA;
      fwd2_wr = 1; fwd2_rd = 4; fwd2_data = 32'hBB;
      tick();
      checks++; if (ex_a !== 32'hAA) begin errors++; $display("FAIL fwd_prio got %h want aa", ex_a); end
      fwd1_wr = 0;
      tick();
      checks++; if (ex_a !== 32'hBB) begin errors++; $display("FAIL fwd2 got %h want bb", ex_a); end
      set_instr(6'h00, 6'h21, 5'd0, 5'd5, 5'd7, 16'h0, 32'h99, 32'h22);
      fwd1_wr = 1; fwd1_rd = 0; fwd1_data = 32'h55; fwd2_wr = 0;
      tick();
      checks++; if (ex_a !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h want 0", ex_a); end
      idle();
   endtask

   task automatic test_load_use();
      idle();
      set_instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h4, 32'h100, 32'h0);
      tick();
      checks++; if (ex_mem_rd !== 1'b1 || ex_dst !== 5'd8) begin errors++; $display("FAIL lw got mr=%b dst=%0d want 1 8", ex_mem_rd, ex_dst); end
      set_instr(6'h00, 6'h20, 5'd8, 5'd2, 5'd9, 16'h0, 32'hDEAD, 32'h22);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL luh_ready got %b want 0", in_ready); end
      tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL luh_bubble got %b want 0", ex_valid); end
      fwd1_wr = 1; fwd1_rd = 8; fwd1_data = 32'h1234;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL luh_release got %b want 1", in_ready); end
      tick();
      checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h1234 || ex_b !== 32'h22) begin
         errors++; $display("FAIL luh_retry got v=%b a=%h b=%h want 1 1234 22", ex_valid, ex_a, ex_b); end
      idle();
   endtask

   task automatic test_stall_flush();
      idle();
      set_instr(6'h00, 6'h24, 5'd1, 5'd2, 5'd5, 16'h0, 32'h11, 32'h22);
      tick();
      stall = 1;
      set_instr(6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 16'h7, 32'h33, 32'h44);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_b !== 32'h22 || ex_dst !== 5'd5 || ex_alucon !== 3'b010) begin
            errors++; $display("FAIL stall_hold%0d got v=%b a=%h b=%h dst=%0d alu=%b want 1 11 22 5 010", i, ex_valid, ex_a, ex_b, ex_dst, ex_alucon); end
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", in_ready); end
      flush = 1;
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_wr !== 1'b0 || ex_alucon !== 3'b111) begin
         errors++; $display("FAIL flush_stall got v=%b wr=%b alu=%b want 0 0 111", ex_valid, ex_wr, ex_alucon); end
      flush = 0; stall = 0;
      set_instr(6'h00, 6'h25, 5'd1, 5'd2, 5'd5, 16'h0, 32'h11, 32'h22);
      tick();
      stall = 1; rst = 1;
      tick();
      checks++; if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_b !== 32'h0 || ex_wr !== 1'b0 || ex_dst !== 5'd0 || ex_alucon !== 3'b111) begin
         errors++; $display("FAIL rst_stall got v=%b a=%h b=%h wr=%b dst=%0d alu=%b want 0 0 0 0 0 111", ex_valid, ex_a, ex_b, ex_wr, ex_dst, ex_alucon); end
      idle();
   endtask

   task automatic test_random();
      logic [5:0] ops [10];
      logic [5:0] fns [7];
      ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
      idle();
      for (int c = 0; c < 500; c++) begin
         set_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom), $urandom, $urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         fwd1_wr   = $urandom_range(0, 1) == 1; fwd1_rd = 5'($urandom_range(0, 7)); fwd1_data = $urandom;
         fwd2_wr   = $urandom_range(0, 1) == 1; fwd2_rd = 5'($urandom_range(0, 7)); fwd2_data = $urandom;
         stall     = ($urandom_range(0, 5) == 0);
         flush     = ($urandom_range(0, 9) == 0);
         rst       = ($urandom_range(0, 49) == 0);
         #1;
         checks++; if (in_ready !== (!stall && !ref_luh())) begin
            errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, !stall && !ref_luh()); end
         tick();
         checks++; if (ex_valid !== m_valid || ex_alucon !== m_alu || ex_wr !== m_wr || ex_mem_rd !== m_mrd ||
                       ex_mem_wr !== m_mwr || ex_illegal !== m_ill) begin
            errors++; $display("FAIL rnd_ctrl cyc %0d got v=%b alu=%b wr=%b mr=%b mw=%b il=%b want v=%b alu=%b wr=%b mr=%b mw=%b il=%b",
                               c, ex_valid, ex_alucon, ex_wr, ex_mem_rd, ex_mem_wr, ex_illegal, m_valid, m_alu, m_wr, m_mrd, m_mwr, m_ill); end
         if (m_valid) begin
            checks++; if (ex_a !== m_a || ex_b !== m_b || ex_dst !== m_dst || ex_store_data !== m_sd) begin
               errors++; $display("FAIL rnd_data cyc %0d got a=%h b=%h dst=%0d sd=%h want a=%h b=%h dst=%0d sd=%h",
                                  c, ex_a, ex_b, ex_dst, ex_store_data, m_a, m_b, m_dst, m_sd); end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      model_bubble();
      test_reset();
      test_decode();
      test_immediates();
      test_forward();
      test_load_use();
      test_stall_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
